// File: rtl/chaos_seq_ctrl.sv
// chaos_seq_ctrl: sequences the analog chaos core (discharge -> settle -> sample),
//   von Neumann debiases comparator samples and packs them into bytes.
// Latency: comparator bit reaches a strobe after 2 sync flops; a completed byte
//   appears on byte_o/valid_o one cycle after the completing strobe.
// Backpressure: one output slot; a byte that completes while the slot is full
//   and not being drained is dropped and flagged on sticky overflow_o.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               level run request (0 returns the sequencer to IDLE)
//   comp_in             asynchronous comparator bit from the chaos core
//   discharge_o, run_o  analog core controls
//   byte_o, valid_o     packed random byte, accepted when valid_o & ready_i
//   ready_i             consumer ready
//   busy_o              sequencer not in IDLE
//   overflow_o          sticky: a completed byte was dropped
//
// Build option: define CHAOS_RAW_EN to bypass the debiaser (each strobe is a bit).

module chaos_seq_ctrl #(
  parameter int DISCHARGE_CYC = 16,
  parameter int SETTLE_CYC    = 64,
  parameter int SAMPLE_DIV    = 8,
  parameter int RESEED_BYTES  = 0,
  parameter int CNT_W         = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       comp_in,
  output logic       discharge_o,
  output logic       run_o,
  output logic [7:0] byte_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       busy_o,
  output logic       overflow_o
);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_DISCHARGE = 2'd1;
  localparam logic [1:0] ST_SETTLE    = 2'd2;
  localparam logic [1:0] ST_SAMPLE    = 2'd3;

  localparam logic [CNT_W-1:0] DIS_LAST = CNT_W'(DISCHARGE_CYC - 1);
  localparam logic [CNT_W-1:0] SET_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(SAMPLE_DIV - 1);
  localparam logic [15:0]      RB_LAST  = 16'(RESEED_BYTES - 1);

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [CNT_W-1:0] phase_cnt;
  logic [CNT_W-1:0] div_cnt;
  logic             comp_s1;
  logic             comp_s2;
  logic [6:0]       shift;
  logic [2:0]       bit_cnt;
  logic [15:0]      byte_cnt;

  logic       strobe;
  logic       bit_vld;
  logic       bit_dat;
  logic       byte_done;
  logic       reseed;
  logic       keep_smp;
  logic [7:0] new_byte;

  // Analog controls and busy decode directly from the state register.
  assign discharge_o = (state == ST_DISCHARGE);
  assign run_o       = (state == ST_SETTLE) || (state == ST_SAMPLE);
  assign busy_o      = (state != ST_IDLE);

  // Strobe is suppressed on the cycle start drops so nothing completes while leaving.
  assign strobe = (state == ST_SAMPLE) && start && (div_cnt == DIV_LAST);

`ifdef CHAOS_RAW_EN
  assign bit_vld = strobe;
  assign bit_dat = comp_s2;
`else
  // Pair state: pair_half=1 means the first sample (a) of a pair is held in pair_a.
  logic pair_half;
  logic pair_a;

  // 01 emits 1 and 10 emits 0, so the emitted bit is simply the second sample.
  assign bit_vld = strobe && pair_half && (pair_a != comp_s2);
  assign bit_dat = comp_s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pair_half <= 1'b0;
      pair_a    <= 1'b0;
    end else if (!keep_smp) begin
      pair_half <= 1'b0;
      pair_a    <= 1'b0;
    end else if (strobe) begin
      pair_half <= ~pair_half;
      pair_a    <= comp_s2;
    end
  end
`endif

  assign new_byte  = {shift, bit_dat};
  assign byte_done = bit_vld && (bit_cnt == 3'd7);
  assign reseed    = (RESEED_BYTES > 0) && byte_done && (byte_cnt == RB_LAST);
  // Partial byte/pair state only survives while the FSM stays in SAMPLE.
  assign keep_smp  = (state == ST_SAMPLE) && (state_nxt == ST_SAMPLE);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_DISCHARGE;
      end
      ST_DISCHARGE: begin
        if (!start)                      state_nxt = ST_IDLE;
        else if (phase_cnt == DIS_LAST)  state_nxt = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (!start)                      state_nxt = ST_IDLE;
        else if (phase_cnt == SET_LAST)  state_nxt = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        if (!start)      state_nxt = ST_IDLE;
        else if (reseed) state_nxt = ST_DISCHARGE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      phase_cnt <= '0;
      div_cnt   <= '0;
      comp_s1   <= 1'b0;
      comp_s2   <= 1'b0;
    end else begin
      state   <= state_nxt;
      comp_s1 <= comp_in;
      comp_s2 <= comp_s1;

      // Phase counter restarts on every state change.
      if (state_nxt != state)
        phase_cnt <= '0;
      else if ((state == ST_DISCHARGE) || (state == ST_SETTLE))
        phase_cnt <= phase_cnt + CNT_W'(1);
      else
        phase_cnt <= '0;

      // Divider starts at 0 on SAMPLE entry so the first strobe is the SAMPLE_DIV-th cycle.
      if (keep_smp)
        div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + CNT_W'(1);
      else
        div_cnt <= '0;
    end
  end

  // Bit packer: shift left, newest bit at LSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift   <= '0;
      bit_cnt <= '0;
    end else if (!keep_smp) begin
      shift   <= '0;
      bit_cnt <= '0;
    end else if (bit_vld) begin
      shift   <= new_byte[6:0];
      bit_cnt <= bit_cnt + 3'd1;
    end
  end

  // Reseed byte counter counts dropped bytes as well as delivered ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt <= '0;
    end else if (state == ST_IDLE) begin
      byte_cnt <= '0;
    end else if ((RESEED_BYTES > 0) && byte_done) begin
      byte_cnt <= reseed ? '0 : byte_cnt + 16'd1;
    end
  end

  // Single-slot output register; a simultaneous drain frees the slot for the new byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_o     <= 8'h00;
      valid_o    <= 1'b0;
      overflow_o <= 1'b0;
    end else begin
      if (byte_done && (!valid_o || ready_i)) begin
        byte_o  <= new_byte;
        valid_o <= 1'b1;
      end else if (valid_o && ready_i) begin
        valid_o <= 1'b0;
      end
      if (byte_done && valid_o && !ready_i)
        overflow_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_chaos_seq_ctrl.sv
module tb_chaos_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       start_rs;
  logic       comp_in;
  logic       ready;

  logic       dis_a, run_a, vld_a, busy_a, ovf_a;
  logic [7:0] byte_a;
  logic       dis_b, run_b, vld_b, busy_b, ovf_b;
  logic [7:0] byte_b;

  logic       sel;
  logic       obs_dis, obs_run, obs_vld, obs_busy, obs_ovf;
  logic [7:0] obs_byte;

  int total = 0;
  int bad   = 0;
  int busy_low_cnt = 0;
  logic trk = 1'b0;

  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  chaos_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .comp_in(comp_in),
    .discharge_o(dis_a), .run_o(run_a), .byte_o(byte_a), .valid_o(vld_a),
    .ready_i(ready), .busy_o(busy_a), .overflow_o(ovf_a)
  );

  chaos_seq_ctrl #(.RESEED_BYTES(2)) dut_rs (
    .clk(clk), .rst_n(rst_n), .start(start_rs), .comp_in(comp_in),
    .discharge_o(dis_b), .run_o(run_b), .byte_o(byte_b), .valid_o(vld_b),
    .ready_i(ready), .busy_o(busy_b), .overflow_o(ovf_b)
  );

  assign obs_dis  = sel ? dis_b  : dis_a;
  assign obs_run  = sel ? run_b  : run_a;
  assign obs_vld  = sel ? vld_b  : vld_a;
  assign obs_busy = sel ? busy_b : busy_a;
  assign obs_ovf  = sel ? ovf_b  : ovf_a;
  assign obs_byte = sel ? byte_b : byte_a;

  always @(negedge clk) begin
    if (trk && !busy_b) busy_low_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for discharge to rise, then measures its length in cycles.
  // Returns on the first negedge with discharge low, i.e. the first run_o cycle.
  task automatic measure(input int exp_len);
    int n;
    int w;
    int runhi;
    n = 0; w = 0; runhi = 0;
    while (obs_dis !== 1'b1 && w < 100) begin
      @(negedge clk);
      w++;
    end
    while (obs_dis === 1'b1 && n < 1000) begin
      if (obs_run) runhi++;
      @(negedge clk);
      n++;
    end
    chk("dis_len", n, exp_len);
    chk("run_in_dis", runhi, 0);
    chk("run_after_dis", obs_run, 1);
  endtask

  // Holds each strobe value for one 8-cycle divider window, first strobe = s[n-1].
  // pre = valid seen on the last negedge before the final strobe edge.
  task automatic drive_strobes(input logic [31:0] s, input int n, input int lead,
                               output logic pre);
    pre = 1'bx;
    repeat (lead) @(negedge clk);
    for (int i = 0; i < n; i++) begin
      comp_in = s[n-1-i];
      for (int j = 0; j < 8; j++) begin
        if (i == n - 1 && j == 7) pre = obs_vld;
        @(negedge clk);
      end
    end
  endtask

  // Encodes bits (MSB first) into strobes: a pair per bit when debiased, one when raw.
  task automatic drive_bits(input logic [7:0] b, input int nb, input int lead,
                            output logic pre);
    logic [31:0] s;
    int n;
    s = '0;
    n = 0;
    for (int i = nb - 1; i >= 0; i--) begin
`ifdef CHAOS_RAW_EN
      s = {s[30:0], b[i]};
      n = n + 1;
`else
      s = {s[29:0], ~b[i], b[i]};
      n = n + 2;
`endif
    end
    drive_strobes(s, n, lead, pre);
  endtask

  initial begin
    logic pre;
    sel = 1'b0; rst_n = 1'b0; start = 1'b0; start_rs = 1'b0;
    comp_in = 1'b0; ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_dis",  obs_dis, 0);
    chk("rst_run",  obs_run, 0);
    chk("rst_vld",  obs_vld, 0);
    chk("rst_byte", obs_byte, 8'h00);
    chk("rst_busy", obs_busy, 0);
    chk("rst_ovf",  obs_ovf, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Phase timing and first byte (A5), including discarded 00/11 pairs.
    start = 1'b1;
    measure(16);
    chk("busy_run", obs_busy, 1);
    exp_q.push_back(8'hA5);
`ifdef CHAOS_RAW_EN
    drive_bits(8'hA5, 8, 64, pre);
`else
    drive_strobes(32'b0110_0011_0110_1001_1001, 20, 64, pre);
`endif
    chk("a5_pre_vld", pre, 0);
    chk("a5_vld", obs_vld, 1);
    chk("a5_byte", obs_byte, exp_q[0]);

    // Two bytes complete while the slot is full: both dropped.
    drive_bits(8'h3C, 8, 0, pre);
    chk("ovf_set", obs_ovf, 1);
    chk("ovf_hold1", obs_byte, exp_q[0]);
    drive_bits(8'h81, 8, 0, pre);
    chk("ovf_hold2", obs_byte, exp_q[0]);
    chk("ovf_vld", obs_vld, 1);
    ready = 1'b1;
    chk("xfer_byte", obs_byte, exp_q.pop_front());
    @(negedge clk);
    chk("xfer_vld", obs_vld, 0);
    chk("xfer_ovf", obs_ovf, 1);
    chk("xfer_hold", obs_byte, 8'hA5);
    start = 1'b0;
    @(negedge clk);
    chk("idle_busy", obs_busy, 0);
    chk("idle_run", obs_run, 0);
    chk("idle_ovf", obs_ovf, 1);

    // Abort after 3 bits, restart: stale bits must not leak into the next byte.
    start = 1'b1;
    measure(16);
    drive_bits(8'h00, 3, 64, pre);
    chk("part_vld", obs_vld, 0);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("abort_busy", obs_busy, 0);
    start = 1'b1;
    measure(16);
    exp_q.push_back(8'hFF);
    drive_bits(8'hFF, 8, 64, pre);
    chk("ff_pre_vld", pre, 0);
    chk("ff_vld", obs_vld, 1);
    chk("ff_byte", obs_byte, exp_q.pop_front());
    @(negedge clk);
    chk("ff_drain", obs_vld, 0);
    start = 1'b0;
    repeat (2) @(negedge clk);

    // Reseed after two bytes on the RESEED_BYTES=2 instance.
    sel = 1'b1;
    start_rs = 1'b1;
    measure(16);
    trk = 1'b1;
    exp_q.push_back(8'h12);
    drive_bits(8'h12, 8, 64, pre);
    chk("rs1_vld", obs_vld, 1);
    chk("rs1_byte", obs_byte, exp_q.pop_front());
    exp_q.push_back(8'h34);
    drive_bits(8'h34, 8, 0, pre);
    chk("rs2_vld", obs_vld, 1);
    chk("rs2_byte", obs_byte, exp_q.pop_front());
    chk("rs_dis_now", obs_dis, 1);
    measure(16);
    exp_q.push_back(8'h56);
    drive_bits(8'h56, 8, 64, pre);
    chk("rs3_pre_vld", pre, 0);
    chk("rs3_vld", obs_vld, 1);
    chk("rs3_byte", obs_byte, exp_q.pop_front());
    trk = 1'b0;
    chk("rs_busy_held", busy_low_cnt, 0);
    start_rs = 1'b0;
    repeat (2) @(negedge clk);
    sel = 1'b0;

    // Asynchronous reset in SAMPLE with a byte pending.
    ready = 1'b0;
    start = 1'b1;
    measure(16);
    exp_q.push_back(8'h5A);
    drive_bits(8'h5A, 8, 64, pre);
    chk("pre_rst_vld", obs_vld, 1);
    chk("pre_rst_byte", obs_byte, exp_q.pop_front());
    #2 rst_n = 1'b0;
    #1;
    chk("arst_dis",  obs_dis, 0);
    chk("arst_run",  obs_run, 0);
    chk("arst_vld",  obs_vld, 0);
    chk("arst_byte", obs_byte, 8'h00);
    chk("arst_busy", obs_busy, 0);
    chk("arst_ovf",  ovf_a, 0);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    chk("sb_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
